// File: rtl/digit_display_pkg.sv
// Shared definitions for the digit display scheduler.
// Holds the digit cell geometry, the 3-digit BCD record, the conversion
// scheduler state encoding and small helpers that read a BCD record.
package digit_display_pkg;

  localparam int DIGIT_W          = 16;
  localparam int DIGIT_H          = 32;
  localparam int DIGITS_PER_FIELD = 3;
  localparam int BIN_W            = 8;
  localparam int SHIFT_CYCLES     = 8;

  // Three BCD digits of one field, hundreds in the top nibble.
  typedef struct packed {
    logic [3:0] hundreds;
    logic [3:0] tens;
    logic [3:0] units;
  } bcd3_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_NEXT,
    ST_COMMIT
  } sched_state_t;

  // Digit k of a field, k=0 is hundreds.
  function automatic logic [3:0] bcd_digit(input bcd3_t b, input int k);
    case (k)
      0:       return b.hundreds;
      1:       return b.tens;
      default: return b.units;
    endcase
  endfunction

  // Leading-zero blanking: units always shown, tens only if something
  // precedes it or it is itself non-zero.
  function automatic logic lead_visible(input bcd3_t b, input int k);
    case (k)
      0:       return (b.hundreds != 4'd0);
      1:       return (b.hundreds != 4'd0) || (b.tens != 4'd0);
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble).
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   start        load bin_in and clear the BCD accumulator
//   shift        perform one add-3/shift step (ignored once 8 steps are done)
//   bin_in       binary value to convert, sampled on start
//   bcd_out      BCD accumulator; holds the result once done is high
//   last_shift   the step being taken this cycle is the final one
//   done         all 8 steps completed since the last start
module bin2bcd_seq
  import digit_display_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             shift,
  input  logic [BIN_W-1:0] bin_in,
  output bcd3_t            bcd_out,
  output logic             last_shift,
  output logic             done
);

  logic [BIN_W-1:0] bin_q, bin_d;
  bcd3_t            bcd_q, bcd_d;
  logic [3:0]       cnt_q, cnt_d;
  bcd3_t            adj;
  logic [19:0]      shifted;

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? n + 4'd3 : n;
  endfunction

  // One double-dabble step: correct every nibble that would overflow past 9
  // after doubling, then shift the binary MSB into the BCD LSB.
  always_comb begin
    bin_d        = bin_q;
    bcd_d        = bcd_q;
    cnt_d        = cnt_q;
    adj.hundreds = add3(bcd_q.hundreds);
    adj.tens     = add3(bcd_q.tens);
    adj.units    = add3(bcd_q.units);
    shifted      = {adj, bin_q} << 1;
    if (start) begin
      bin_d = bin_in;
      bcd_d = '0;
      cnt_d = 4'd0;
    end else if (shift && (cnt_q < 4'(SHIFT_CYCLES))) begin
      bcd_d = bcd3_t'(shifted[19:8]);
      bin_d = shifted[7:0];
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bin_q <= '0;
      bcd_q <= '0;
      cnt_q <= '0;
    end else begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
    end
  end

  assign bcd_out    = bcd_q;
  assign last_shift = shift && (cnt_q == 4'(SHIFT_CYCLES - 1));
  assign done       = (cnt_q == 4'(SHIFT_CYCLES));

endmodule

// File: rtl/digit_display_scheduler.sv
// Time-shares one 16x32 digit bitmap ROM between NUM_VALUES numeric fields.
// Each field shows an 8-bit value as three decimal digits with leading-zero
// blanking. Values are captured at startOfFrame, converted to BCD one field
// at a time by a shared sequential converter, and committed to the display
// registers together so a frame never shows a half-updated set of fields.
// Ports:
//   clk, reset           system clock, synchronous active-high reset
//   startOfFrame         1-cycle pulse at start of vertical blank
//   pixelX, pixelY       current pixel position
//   values               field values, field 0 in the most significant byte
//                        (written {field0, field1, ...})
//   blink_en             bit i enables blinking of field i
//   rom_digit            digit 0..9 for the shared bitmap ROM
//   rom_offsetX/Y        position inside the 16x32 cell
//   rom_insideRectangle  pixel lies in a visible digit cell
//   field_id             field covering the pixel
//   busy                 BCD conversion in progress
// FIELD_X/FIELD_Y are packed the same way as values: field 0 first.
module digit_display_scheduler
  import digit_display_pkg::*;
#(
  parameter int                     NUM_VALUES   = 2,
  parameter logic [NUM_VALUES*11-1:0] FIELD_X    = {11'd32, 11'd560},
  parameter logic [NUM_VALUES*11-1:0] FIELD_Y    = {11'd16, 11'd16},
  parameter logic [5:0]             BLINK_FRAMES = 6'd30
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic [10:0]             pixelX,
  input  logic [10:0]             pixelY,
  input  logic [NUM_VALUES*8-1:0] values,
  input  logic [NUM_VALUES-1:0]   blink_en,
  output logic [3:0]              rom_digit,
  output logic [3:0]              rom_offsetX,
  output logic [4:0]              rom_offsetY,
  output logic                    rom_insideRectangle,
  output logic [1:0]              field_id,
  output logic                    busy
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_VALUES - 1);

  sched_state_t state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [7:0]   lat_q    [NUM_VALUES];
  logic [7:0]   lat_d    [NUM_VALUES];
  bcd3_t        shadow_q [NUM_VALUES];
  bcd3_t        shadow_d [NUM_VALUES];
  bcd3_t        disp_q   [NUM_VALUES];
  bcd3_t        disp_d   [NUM_VALUES];

  logic [5:0]   blink_cnt_q, blink_cnt_d;
  logic         blink_off_q, blink_off_d;

  logic [3:0]   rom_digit_q, rom_digit_d;
  logic [3:0]   rom_offset_x_q, rom_offset_x_d;
  logic [4:0]   rom_offset_y_q, rom_offset_y_d;
  logic         inside_q, inside_d;
  logic [1:0]   field_id_q, field_id_d;

  logic         conv_start, conv_shift, conv_last, conv_done;
  logic [1:0]   sel_idx;
  logic [7:0]   bin_sel;
  bcd3_t        conv_bcd;

  function automatic logic [10:0] field_x(input int i);
    return FIELD_X[(NUM_VALUES-1-i)*11 +: 11];
  endfunction

  function automatic logic [10:0] field_y(input int i);
    return FIELD_Y[(NUM_VALUES-1-i)*11 +: 11];
  endfunction

  bin2bcd_seq u_bin2bcd (
    .clk        (clk),
    .reset      (reset),
    .start      (conv_start),
    .shift      (conv_shift),
    .bin_in     (bin_sel),
    .bcd_out    (conv_bcd),
    .last_shift (conv_last),
    .done       (conv_done)
  );

  // Conversion scheduler. The next field's value is loaded into the
  // converter in NEXT while the finished result is stored, so each field
  // costs exactly 8 shift cycles plus one NEXT cycle.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    shadow_d   = shadow_q;
    disp_d     = disp_q;
    conv_start = 1'b0;
    conv_shift = 1'b0;
    sel_idx    = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (startOfFrame) begin
          for (int i = 0; i < NUM_VALUES; i++) begin
            lat_d[i] = values[(NUM_VALUES-1-i)*8 +: 8];
          end
          idx_d   = 2'd0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        conv_start = 1'b1;
        sel_idx    = 2'd0;
        state_d    = ST_SHIFT;
      end
      ST_SHIFT: begin
        conv_shift = 1'b1;
        if (conv_last) begin
          state_d = ST_NEXT;
        end
      end
      ST_NEXT: begin
        for (int i = 0; i < NUM_VALUES; i++) begin
          if (conv_done && (idx_q == 2'(i))) begin
            shadow_d[i] = conv_bcd;
          end
        end
        if (idx_q == LAST_IDX) begin
          state_d = ST_COMMIT;
        end else begin
          idx_d      = idx_q + 2'd1;
          sel_idx    = idx_q + 2'd1;
          conv_start = 1'b1;
          state_d    = ST_SHIFT;
        end
      end
      ST_COMMIT: begin
        disp_d  = shadow_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bin_sel = '0;
    for (int i = 0; i < NUM_VALUES; i++) begin
      if (sel_idx == 2'(i)) begin
        bin_sel = lat_q[i];
      end
    end
  end

  // Blink frame counter: counts every startOfFrame, even those arriving
  // while a conversion is still running, so blink timing stays regular.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_off_d = blink_off_q;
    if (startOfFrame) begin
      if (blink_cnt_q == BLINK_FRAMES - 6'd1) begin
        blink_cnt_d = 6'd0;
        blink_off_d = ~blink_off_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 6'd1;
      end
    end
  end

  // Pixel hit test. Comparisons are done in 12 bits so a cell near the
  // right/bottom edge cannot wrap around to column/row 0. Fields are
  // scanned from index 0 upward and the first covering cell claims the pixel.
  always_comb begin
    logic [11:0] px, py, cell_x, cell_y;
    logic        found;
    px             = {1'b0, pixelX};
    py             = {1'b0, pixelY};
    cell_x         = '0;
    cell_y         = '0;
    found          = 1'b0;
    rom_digit_d    = '0;
    rom_offset_x_d = '0;
    rom_offset_y_d = '0;
    inside_d       = 1'b0;
    field_id_d     = '0;
    for (int i = 0; i < NUM_VALUES; i++) begin
      for (int k = 0; k < DIGITS_PER_FIELD; k++) begin
        cell_x = {1'b0, field_x(i)} + 12'(DIGIT_W * k);
        cell_y = {1'b0, field_y(i)};
        if (!found && (px >= cell_x) && (px <= cell_x + 12'(DIGIT_W - 1)) &&
            (py >= cell_y) && (py <= cell_y + 12'(DIGIT_H - 1))) begin
          found      = 1'b1;
          field_id_d = 2'(i);
          if (lead_visible(disp_q[i], k) && !(blink_en[i] && blink_off_q)) begin
            inside_d       = 1'b1;
            rom_digit_d    = bcd_digit(disp_q[i], k);
            rom_offset_x_d = 4'(px - cell_x);
            rom_offset_y_d = 5'(py - cell_y);
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      idx_q          <= '0;
      blink_cnt_q    <= '0;
      blink_off_q    <= 1'b0;
      rom_digit_q    <= '0;
      rom_offset_x_q <= '0;
      rom_offset_y_q <= '0;
      inside_q       <= 1'b0;
      field_id_q     <= '0;
      for (int i = 0; i < NUM_VALUES; i++) begin
        lat_q[i]    <= '0;
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      blink_cnt_q    <= blink_cnt_d;
      blink_off_q    <= blink_off_d;
      rom_digit_q    <= rom_digit_d;
      rom_offset_x_q <= rom_offset_x_d;
      rom_offset_y_q <= rom_offset_y_d;
      inside_q       <= inside_d;
      field_id_q     <= field_id_d;
      lat_q          <= lat_d;
      shadow_q       <= shadow_d;
      disp_q         <= disp_d;
    end
  end

  assign rom_digit           = rom_digit_q;
  assign rom_offsetX         = rom_offset_x_q;
  assign rom_offsetY         = rom_offset_y_q;
  assign rom_insideRectangle = inside_q;
  assign field_id            = field_id_q;
  assign busy                = (state_q != ST_IDLE);

endmodule

// File: tb/tb_digit_display_scheduler.sv
// Self-checking bench for digit_display_scheduler: fixed vector tables,
// hand-written multi-cycle sequences and randomized frames compared with an
// arithmetic reference model of the on-screen digits.
module tb_digit_display_scheduler;

  localparam int BF = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        startOfFrame;
  logic [10:0] pixelX, pixelY;
  logic [15:0] values;
  logic [1:0]  blink_en;
  logic [3:0]  rom_digit, rom_offsetX;
  logic [4:0]  rom_offsetY;
  logic        rom_insideRectangle;
  logic [1:0]  field_id;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int nsof     = 0;
  int mval[2];
  int fx[2] = '{32, 560};
  int fy[2] = '{16, 16};

  typedef struct {
    int set;
    int px;
    int py;
    int code;
  } vec_t;
  vec_t tab[18];

  digit_display_scheduler #(
    .NUM_VALUES   (2),
    .FIELD_X      ({11'd32, 11'd560}),
    .FIELD_Y      ({11'd16, 11'd16}),
    .BLINK_FRAMES (6'd2)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .startOfFrame        (startOfFrame),
    .pixelX              (pixelX),
    .pixelY              (pixelY),
    .values              (values),
    .blink_en            (blink_en),
    .rom_digit           (rom_digit),
    .rom_offsetX         (rom_offsetX),
    .rom_offsetY         (rom_offsetY),
    .rom_insideRectangle (rom_insideRectangle),
    .field_id            (field_id),
    .busy                (busy)
  );

  always #5 clk = ~clk;

  function automatic int mk(input int fid, input int dig, input int ox, input int oy);
    return (fid << 20) | (1 << 16) | (dig << 12) | (ox << 8) | oy;
  endfunction

  // Reference: which decimal digit of which field sits under the pixel.
  function automatic int model_code(input int px, input int py);
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 3; k++) begin
        int cx, v, d;
        bit vis;
        cx = fx[i] + 16 * k;
        if (px >= cx && px <= cx + 15 && py >= fy[i] && py <= fy[i] + 31) begin
          v   = mval[i];
          d   = (k == 0) ? v / 100 : (k == 1) ? (v / 10) % 10 : v % 10;
          vis = (k == 2) || (k == 1 && v >= 10) || (k == 0 && v >= 100);
          if (blink_en[i] && ((nsof / BF) % 2 == 1)) vis = 0;
          return vis ? mk(i, d, px - cx, py - fy[i]) : 0;
        end
      end
    end
    return 0;
  endfunction

  function automatic int act_code();
    if (rom_insideRectangle)
      return mk(int'(field_id), int'(rom_digit), int'(rom_offsetX), int'(rom_offsetY));
    return (int'(rom_digit) << 12) | (int'(rom_offsetX) << 8) | int'(rom_offsetY);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input int px, input int py);
    pixelX = 11'(px);
    pixelY = 11'(py);
    step();
  endtask

  task automatic checkPixel(input string name, input int px, input int py);
    applyStimulus(px, py);
    checkOutput(name, act_code(), model_code(px, py));
  endtask

  task automatic waitIdle(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      step();
    end
    if (busy) checkOutput("busy_timeout", 1, 0);
  endtask

  task automatic runFrame(input logic [15:0] v, output int n);
    values       = v;
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    nsof++;
    waitIdle(n);
    mval[0] = int'(v[15:8]);
    mval[1] = int'(v[7:0]);
  endtask

  task automatic runTable(input int set);
    for (int i = 0; i < 18; i++) begin
      if (tab[i].set == set) begin
        applyStimulus(tab[i].px, tab[i].py);
        checkOutput($sformatf("table%0d_%0d_%0d", set, tab[i].px, tab[i].py),
                    act_code(), tab[i].code);
      end
    end
  endtask

  initial begin
    int n;
    tab[0]  = '{0, 51, 21, mk(0, 5, 3, 5)};
    tab[1]  = '{0, 32, 16, mk(0, 2, 0, 0)};
    tab[2]  = '{0, 79, 47, mk(0, 5, 15, 31)};
    tab[3]  = '{0, 64, 30, mk(0, 5, 0, 14)};
    tab[4]  = '{0, 80, 20, 0};
    tab[5]  = '{0, 40, 48, 0};
    tab[6]  = '{0, 31, 16, 0};
    tab[7]  = '{0, 565, 20, 0};
    tab[8]  = '{0, 580, 20, 0};
    tab[9]  = '{0, 600, 30, mk(1, 7, 8, 14)};
    tab[10] = '{0, 607, 47, mk(1, 7, 15, 31)};
    tab[11] = '{0, 592, 15, 0};
    tab[12] = '{1, 40, 20, 0};
    tab[13] = '{1, 50, 20, 0};
    tab[14] = '{1, 70, 20, mk(0, 0, 6, 4)};
    tab[15] = '{1, 561, 17, mk(1, 1, 1, 1)};
    tab[16] = '{1, 577, 17, mk(1, 0, 1, 1)};
    tab[17] = '{1, 593, 17, mk(1, 0, 1, 1)};

    reset        = 1'b1;
    startOfFrame = 1'b0;
    pixelX       = '0;
    pixelY       = '0;
    values       = '0;
    blink_en     = '0;
    mval[0]      = 0;
    mval[1]      = 0;
    step(); step(); step();
    checkOutput("reset_outputs", act_code() | (int'(field_id) << 20), 0);
    checkOutput("reset_busy", int'(busy), 0);
    reset = 1'b0;
    checkPixel("reset_display_units", 70, 20);

    // First frame: latency and the tabulated pixels.
    runFrame({8'd255, 8'd7}, n);
    checkOutput("busy_cycles", n, 20);
    runTable(0);

    runFrame({8'd0, 8'd100}, n);
    runTable(1);

    // Values change without a frame start: display must hold.
    values = {8'd1, 8'd2};
    repeat (30) step();
    applyStimulus(70, 20);
    checkOutput("hold_old_digit", act_code(), mk(0, 0, 6, 4));
    runFrame({8'd1, 8'd2}, n);
    checkPixel("new_field0_units", 70, 20);
    checkPixel("new_field1_units", 600, 20);

    // A second frame start during a conversion is ignored.
    values       = {8'd9, 8'd8};
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    nsof++;
    repeat (4) step();
    values       = {8'd44, 8'd44};
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    nsof++;
    waitIdle(n);
    checkOutput("ignored_sof_busy", n, 15);
    mval[0] = 9;
    mval[1] = 8;
    checkPixel("ignored_sof_field0", 70, 20);
    checkPixel("ignored_sof_field1", 600, 20);
    runFrame({8'd44, 8'd44}, n);
    checkPixel("after_ignored_tens", 50, 20);

    // Reset while the converter is shifting.
    pixelX       = 11'd70;
    pixelY       = 11'd20;
    values       = {8'd123, 8'd45};
    startOfFrame = 1'b1;
    step();
    startOfFrame = 1'b0;
    step(); step();
    reset = 1'b1;
    step();
    checkOutput("midshift_reset_outputs", act_code() | (int'(field_id) << 20), 0);
    checkOutput("midshift_reset_busy", int'(busy), 0);
    reset   = 1'b0;
    nsof    = 0;
    mval[0] = 0;
    mval[1] = 0;
    checkPixel("midshift_display_f0", 70, 20);
    checkPixel("midshift_display_hund", 32, 16);
    checkPixel("midshift_display_f1", 600, 20);

    // Blink on field 0 only.
    blink_en = 2'b01;
    for (int f = 0; f < 6; f++) begin
      runFrame({8'd188, 8'd188}, n);
      checkPixel($sformatf("blink_f0_frame%0d", f), 70, 20);
      checkPixel($sformatf("blink_f1_frame%0d", f), 600, 20);
    end

    // Randomized frames and pixels around both fields.
    for (int f = 0; f < 30; f++) begin
      blink_en = 2'($urandom_range(0, 3));
      runFrame(16'($urandom), n);
      for (int p = 0; p < 6; p++) begin
        int fs, px, py;
        fs = $urandom_range(0, 1);
        px = fx[fs] - 8 + $urandom_range(0, 63);
        py = 10 + $urandom_range(0, 43);
        checkPixel($sformatf("rand_f%0d_p%0d", f, p), px, py);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
